// File: rtl/gcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : gcd_pkg
// Purpose  : Shared definitions for the binary (Stein) GCD engine: FSM state
//            encoding, one-hot datapath step-select indices and a clog2 helper
//            used to size the common-power-of-two shift counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gcd_pkg;

  // FSM state encoding (shared by control and any debug logic)
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_STRIP  = 2'd1;
  localparam logic [1:0] c_REDUCE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  // One-hot step selects driven by control into the datapath.
  // At most one bit is set in any cycle; all-zero means "hold".
  localparam int c_STEP_N      = 9;
  localparam int c_STEP_LOAD   = 0;  // capture operands, clear k and cnt
  localparam int c_STEP_ZERO   = 1;  // zero-operand short-circuit result
  localparam int c_STEP_STRIP  = 2;  // both even: halve both, k++
  localparam int c_STEP_HOLD   = 3;  // leave STRIP, data unchanged, count cycle
  localparam int c_STEP_HALF_A = 4;  // a even: a >>= 1
  localparam int c_STEP_HALF_B = 5;  // b even: b >>= 1
  localparam int c_STEP_SUB_A  = 6;  // a > b : a = (a-b) >> 1
  localparam int c_STEP_SUB_B  = 7;  // b > a : b = (b-a) >> 1
  localparam int c_STEP_FINISH = 8;  // a == b: outR = a << k, iter = cnt+1

  // Ceiling log2 of w; with w >= 2 this is always at least 1.
  function automatic int clog2_w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < w) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_binary_fd.sv
//------------------------------------------------------------------------------
// Module   : gcd_binary_fd
// Purpose  : Datapath of the binary GCD engine. Holds the working operands
//            a/b, the common shift count k, the busy-cycle counter cnt and the
//            output registers outR/iter. All updates are selected by a one-hot
//            step vector from the control FSM.
// Ports    : clk, rst_n          - clock, async active-low reset
//            step               - one-hot step select from control
//            inA, inB           - raw operands (used by LOAD / ZERO steps)
//            a_even, b_even,
//            a_eq_b, a_gt_b     - status of the working operands
//            zero_in            - either raw operand is zero
//            outR, iter         - result and busy-cycle count of last op
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_binary_fd
  import gcd_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = 8,
  parameter int KW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [c_STEP_N-1:0] step,
  input  logic [W-1:0]        inA,
  input  logic [W-1:0]        inB,
  output logic                a_even,
  output logic                b_even,
  output logic                a_eq_b,
  output logic                a_gt_b,
  output logic                zero_in,
  output logic [W-1:0]        outR,
  output logic [IW-1:0]       iter
);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [KW-1:0] r_k;
  logic [IW-1:0] r_cnt;
  logic [W-1:0]  r_out;
  logic [IW-1:0] r_iter;

  logic [W-1:0]  w_diff_ab;
  logic [W-1:0]  w_diff_ba;
  logic [IW-1:0] w_cnt_inc;
  logic          w_counting;

  // Only used when the minuend is the larger operand, so neither wraps.
  assign w_diff_ab = r_a - r_b;
  assign w_diff_ba = r_b - r_a;

  // Saturating increment; also serves as iter on the finishing cycle,
  // since the finishing REDUCE cycle itself is a counted busy cycle.
  assign w_cnt_inc = (r_cnt == {IW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Every STRIP and REDUCE cycle issues exactly one of these steps.
  assign w_counting = step[c_STEP_STRIP]  | step[c_STEP_HOLD]   |
                      step[c_STEP_HALF_A] | step[c_STEP_HALF_B] |
                      step[c_STEP_SUB_A]  | step[c_STEP_SUB_B]  |
                      step[c_STEP_FINISH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_iter <= '0;
    end else begin
      if (step[c_STEP_LOAD]) begin
        r_a   <= inA;
        r_b   <= inB;
        r_k   <= '0;
        r_cnt <= '0;
      end
      if (step[c_STEP_ZERO]) begin
        // gcd(x,0) = x and gcd(0,0) = 0 both fall out of a bitwise OR
        r_out  <= inA | inB;
        r_iter <= '0;
      end
      if (step[c_STEP_STRIP]) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_k <= r_k + 1'b1;
      end
      if (step[c_STEP_HALF_A]) r_a <= r_a >> 1;
      if (step[c_STEP_HALF_B]) r_b <= r_b >> 1;
      // Difference of two odd numbers is even, so the halving drops no bit.
      if (step[c_STEP_SUB_A])  r_a <= {1'b0, w_diff_ab[W-1:1]};
      if (step[c_STEP_SUB_B])  r_b <= {1'b0, w_diff_ba[W-1:1]};
      if (step[c_STEP_FINISH]) begin
        r_out  <= r_a << r_k;
        r_iter <= w_cnt_inc;
      end
      if (w_counting) r_cnt <= w_cnt_inc;
    end
  end

  assign a_even  = ~r_a[0];
  assign b_even  = ~r_b[0];
  assign a_eq_b  = (r_a == r_b);
  assign a_gt_b  = (r_a > r_b);
  assign zero_in = (inA == '0) | (inB == '0);
  assign outR    = r_out;
  assign iter    = r_iter;

endmodule

`default_nettype wire

// File: rtl/gcd_binary.sv
//------------------------------------------------------------------------------
// Module   : gcd_binary
// Purpose  : Iterative binary (Stein) GCD engine with start/done level
//            handshake. Control FSM lives here; the datapath is gcd_binary_fd.
// Ports    : clk, rst_n   - clock, async active-low reset
//            start        - level request, sampled in IDLE and DONE
//            inA, inB     - operands, captured on the start edge
//            busy         - high in STRIP / REDUCE
//            done         - high in DONE
//            outR         - result, held until the next capture
//            iter         - busy cycles of the last operation (saturating)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_binary
  import gcd_pkg::*;
#(
  parameter int W  = 16,   // must be >= 2
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  inA,
  input  logic [W-1:0]  inB,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  outR,
  output logic [IW-1:0] iter
);

  localparam int KW = clog2_w(W);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [c_STEP_N-1:0] w_step;

  logic w_a_even;
  logic w_b_even;
  logic w_a_eq_b;
  logic w_a_gt_b;
  logic w_zero_in;

  always_comb begin
    w_state_next = r_state;
    w_step       = '0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          if (w_zero_in) begin
            w_step[c_STEP_ZERO] = 1'b1;
            w_state_next        = c_DONE;
          end else begin
            w_step[c_STEP_LOAD] = 1'b1;
            w_state_next        = c_STRIP;
          end
        end
      end
      c_STRIP: begin
        if (w_a_even && w_b_even) begin
          w_step[c_STEP_STRIP] = 1'b1;
        end else begin
          w_step[c_STEP_HOLD] = 1'b1;
          w_state_next        = c_REDUCE;
        end
      end
      c_REDUCE: begin
        // Priority order matters: equality ends the loop before any
        // halving, and halving an even operand precedes subtraction.
        if (w_a_eq_b) begin
          w_step[c_STEP_FINISH] = 1'b1;
          w_state_next          = c_DONE;
        end else if (w_a_even) begin
          w_step[c_STEP_HALF_A] = 1'b1;
        end else if (w_b_even) begin
          w_step[c_STEP_HALF_B] = 1'b1;
        end else if (w_a_gt_b) begin
          w_step[c_STEP_SUB_A] = 1'b1;
        end else begin
          w_step[c_STEP_SUB_B] = 1'b1;
        end
      end
      c_DONE: begin
        // No auto-restart: start must fall and rise again via IDLE.
        if (!start) w_state_next = c_IDLE;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  // Moore outputs from registered state only.
  assign busy = (r_state == c_STRIP) || (r_state == c_REDUCE);
  assign done = (r_state == c_DONE);

  gcd_binary_fd #(
    .W  (W),
    .IW (IW),
    .KW (KW)
  ) u_fd (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (w_step),
    .inA     (inA),
    .inB     (inB),
    .a_even  (w_a_even),
    .b_even  (w_b_even),
    .a_eq_b  (w_a_eq_b),
    .a_gt_b  (w_a_gt_b),
    .zero_in (w_zero_in),
    .outR    (outR),
    .iter    (iter)
  );

endmodule

`default_nettype wire

// File: tb/tb_gcd_binary.sv
//------------------------------------------------------------------------------
// Module   : tb_gcd_binary
// Purpose  : Self-checking bench for gcd_binary (W=16/IW=8 and W=8/IW=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_binary;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] inA, inB;
  logic        busy, done;
  logic [15:0] outR;
  logic [7:0]  iter;

  logic        start8;
  logic [7:0]  inA8, inB8;
  logic        busy8, done8;
  logic [7:0]  outR8;
  logic [2:0]  iter8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcd_binary #(.W(16), .IW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .outR(outR), .iter(iter)
  );

  gcd_binary #(.W(8), .IW(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .inA(inA8), .inB(inB8),
    .busy(busy8), .done(done8), .outR(outR8), .iter(iter8)
  );

  // ---------------- reference model ----------------
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Busy cycles of one operation, from the algorithm's stated rules.
  function automatic int unsigned ref_cycles(input int unsigned a, input int unsigned b);
    int unsigned x, y, c;
    if (a == 0 || b == 0) return 0;
    x = a; y = b; c = 1;
    while (x % 2 == 0 && y % 2 == 0) begin
      x = x / 2; y = y / 2; c++;
    end
    forever begin
      c++;
      if (x == y) break;
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start with operands and run until done (bounded). start stays high.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int edges, output int busy_cnt);
    inA = a; inB = b; start = 1'b1;
    edges = 0; busy_cnt = 0;
    do begin
      tick();
      edges++;
      if (busy) busy_cnt++;
    end while (!done && edges < 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0;
    inA = '0; inB = '0; inA8 = '0; inB8 = '0;
    repeat (2) tick();
    n_checks++;
    if ({busy, done, outR, iter} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b outR=%0d iter=%0d, expected all 0",
               busy, done, outR, iter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int e, bc;
    logic [15:0] va [4] = '{16'd12, 16'd7, 16'd48, 16'd1};
    logic [15:0] vb [4] = '{16'd18, 16'd7, 16'd180, 16'd65535};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], e, bc);
      n_checks++;
      if (done !== 1'b1 || outR !== 16'(ref_gcd(va[i], vb[i]))) begin
        n_fail++;
        $display("FAIL directed_result(%0d,%0d): got %0d done=%0b, expected %0d",
                 va[i], vb[i], outR, done, ref_gcd(va[i], vb[i]));
      end
      n_checks++;
      if (iter !== 8'(ref_cycles(va[i], vb[i]))) begin
        n_fail++;
        $display("FAIL directed_iter(%0d,%0d): got %0d, expected %0d",
                 va[i], vb[i], iter, ref_cycles(va[i], vb[i]));
      end
      if (i == 0) begin
        n_checks++;
        if (e !== 6 || bc !== 5 || iter !== 8'd5 || outR !== 16'd6) begin
          n_fail++;
          $display("FAIL timing_12_18: got edges=%0d busy=%0d iter=%0d outR=%0d, expected 6 5 5 6",
                   e, bc, iter, outR);
        end
      end
      start = 1'b0;
      tick();
    end
  endtask

  task automatic test_zero();
    int e, bc;
    run_op(16'd0, 16'd25, e, bc);
    n_checks++;
    if (e !== 1 || bc !== 0 || outR !== 16'd25 || iter !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_0_25: got edges=%0d busy=%0d outR=%0d iter=%0d, expected 1 0 25 0",
               e, bc, outR, iter);
    end
    start = 1'b0; tick();
    run_op(16'd0, 16'd0, e, bc);
    n_checks++;
    if (e !== 1 || bc !== 0 || outR !== 16'd0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_0_0: got edges=%0d busy=%0d outR=%0d done=%0b, expected 1 0 0 1",
               e, bc, outR, done);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_handshake();
    int e, bc;
    int bad;
    run_op(16'd48, 16'd180, e, bc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0 || outR !== 16'd12) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_done: got %0d bad cycles (last outR=%0d done=%0b), expected 0",
               bad, outR, done);
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || outR !== 16'd12) begin
      n_fail++;
      $display("FAIL return_idle: got done=%0b busy=%0b outR=%0d, expected 0 0 12",
               done, busy, outR);
    end
    // Operand change while busy must not disturb the result.
    inA = 16'd100; inB = 16'd75; start = 1'b1;
    tick(); tick();
    inA = 16'd7; inB = 16'd3;
    e = 0;
    while (!done && e < 200) begin tick(); e++; end
    n_checks++;
    if (done !== 1'b1 || outR !== 16'd25) begin
      n_fail++;
      $display("FAIL input_isolation: got outR=%0d done=%0b, expected 25 1", outR, done);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    int e, bc;
    inA = 16'd12; inB = 16'd18; start = 1'b1;
    repeat (4) tick();          // now in REDUCE
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || outR !== 16'd0 || iter !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%0b done=%0b outR=%0d iter=%0d, expected all 0",
               busy, done, outR, iter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(16'd12, 16'd18, e, bc);
    n_checks++;
    if (done !== 1'b1 || outR !== 16'd6 || iter !== 8'd5) begin
      n_fail++;
      $display("FAIL after_reset_12_18: got outR=%0d iter=%0d done=%0b, expected 6 5 1",
               outR, iter, done);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_random();
    int e, bc;
    int unsigned g, a, b, exp_r, exp_c;
    for (int i = 0; i < 40; i++) begin
      g = $urandom_range(1, 255);
      a = (g * $urandom_range(0, 255)) & 32'hFFFF;
      b = (g * $urandom_range(0, 255)) & 32'hFFFF;
      if (i % 8 == 0) a = $urandom_range(0, 65535);
      exp_r = ref_gcd(a, b);
      exp_c = ref_cycles(a, b);
      run_op(16'(a), 16'(b), e, bc);
      n_checks++;
      if (done !== 1'b1 || outR !== 16'(exp_r) || iter !== 8'(exp_c) || bc != int'(exp_c)) begin
        n_fail++;
        $display("FAIL random(%0d,%0d): got outR=%0d iter=%0d busy=%0d, expected %0d %0d %0d",
                 a, b, outR, iter, bc, exp_r, exp_c, exp_c);
      end
      start = 1'b0; tick();
    end
  endtask

  task automatic test_saturate();
    int e;
    inA8 = 8'd1; inB8 = 8'd255; start8 = 1'b1;
    e = 0;
    do begin tick(); e++; end while (!done8 && e < 100);
    n_checks++;
    if (done8 !== 1'b1 || outR8 !== 8'd1 || iter8 !== 3'd7) begin
      n_fail++;
      $display("FAIL saturate_w8: got outR=%0d iter=%0d done=%0b, expected 1 7 1",
               outR8, iter8, done8);
    end
    start8 = 1'b0; tick();
    inA8 = 8'd36; inB8 = 8'd24; start8 = 1'b1;
    e = 0;
    do begin tick(); e++; end while (!done8 && e < 100);
    n_checks++;
    if (done8 !== 1'b1 || outR8 !== 8'd12 || iter8 !== 3'(ref_cycles(36, 24) > 7 ? 7 : ref_cycles(36, 24))) begin
      n_fail++;
      $display("FAIL w8_36_24: got outR=%0d iter=%0d, expected 12 %0d",
               outR8, iter8, (ref_cycles(36, 24) > 7 ? 7 : ref_cycles(36, 24)));
    end
    start8 = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_handshake();
    test_async_reset();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
